msg_uart_tx: RTL and testbench

Serialises the team's fixed greeting message ("Hello, World!", optionally followed by CR LF) onto a single UART line, 8N1, LSB first. It sits directly downstream of the shared message package and turns the package-held text into a physical serial stream for the board's debug/console port. A single `start` pulse sends the whole message once, and `done` pulses when the last stop bit has finished.

---
 rtl/msg_pkg.sv | 37 +++
 rtl/msg_uart_tx_if.sv | 12 +
 rtl/uart_tx_byte.sv | 75 +++++++
 rtl/msg_uart_tx.sv | 82 ++++++++
 tb/tb_msg_uart_tx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_pkg.sv
// Greeting text, control characters and state encodings shared by the UART message sender.
// Constants and a byte-select helper only; there is no timing and no flow control.
package msg_pkg;

    localparam int MSG_TEXT_LEN = 13;

    localparam logic [7:0] MSG_TEXT [MSG_TEXT_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
        8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21
    };

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef logic [1:0] top_state_t;
    localparam top_state_t TOP_IDLE      = 2'd0;
    localparam top_state_t TOP_SEND      = 2'd1;
    localparam top_state_t TOP_WAIT_BYTE = 2'd2;
    localparam top_state_t TOP_FINISH    = 2'd3;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

    // Positions past the text map to CR then LF; callers never index beyond the message length.
    function automatic logic [7:0] msg_byte(input logic [3:0] idx);
        if (idx < 4'(MSG_TEXT_LEN))
            return MSG_TEXT[idx];
        else if (idx == 4'(MSG_TEXT_LEN))
            return CHAR_CR;
        else
            return CHAR_LF;
    endfunction

endpackage

// File: rtl/msg_uart_tx_if.sv
// Control and serial-line bundle of the UART message sender.
// Pure wiring; start is accepted only while the sender is idle.
interface msg_uart_tx_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       txd;
    logic [3:0] char_idx;

    modport master (output start, input busy, done, txd, char_idx);
    modport slave  (input start, output busy, done, txd, char_idx);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first; txd follows load by one cycle, frame lasts 10*CLKS_PER_BIT cycles.
// No backpressure: frame_done marks the last stop-bit cycle so a new load may land on the same edge.
module uart_tx_byte
    import msg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end    = (baud_cnt == BAUD_MAX);
    assign frame_done = (state == TX_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else if (load) begin
            state    <= TX_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= data;
            txd      <= 1'b0;
        end else if (state != TX_IDLE) begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    TX_START: begin
                        state   <= TX_DATA;
                        bit_cnt <= 4'd1;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                    TX_DATA: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        // bit_cnt 8 is the MSB; the stop bit follows it
                        if (bit_cnt == 4'd8) begin
                            state <= TX_STOP;
                            txd   <= 1'b1;
                        end else begin
                            txd   <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                    TX_STOP: begin
                        state   <= TX_IDLE;
                        bit_cnt <= '0;
                        txd     <= 1'b1;
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/msg_uart_tx.sv
// Sends the greeting (optionally + CR LF) once per start; txd start bit one cycle after start is taken.
// start is ignored while busy; done pulses one cycle after the final stop bit ends.
module msg_uart_tx
    import msg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    msg_uart_tx_if.slave  bus
);

    localparam int MSG_LEN = APPEND_CRLF ? MSG_TEXT_LEN + 2 : MSG_TEXT_LEN;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    top_state_t state;
    logic [3:0] idx;
    logic       busy_r;
    logic       done_r;
    logic       frame_done;
    logic       launch_first;
    logic       launch_next;
    logic       load;
    logic [7:0] load_data;

    assign launch_first = (state == TOP_IDLE) && bus.start;
    assign launch_next  = (state == TOP_WAIT_BYTE) && frame_done && (idx != LAST_IDX);
    assign load         = launch_first || launch_next;
    assign load_data    = msg_byte(launch_first ? 4'd0 : idx + 4'd1);

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (load_data),
        .txd        (bus.txd),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= TOP_IDLE;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                TOP_IDLE: begin
                    if (bus.start) begin
                        state  <= TOP_WAIT_BYTE;
                        idx    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                TOP_WAIT_BYTE: begin
                    // idx advances on the same edge the next start bit is launched
                    if (frame_done) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + 4'd1;
                        end else begin
                            state  <= TOP_FINISH;
                            idx    <= '0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                TOP_FINISH, TOP_SEND: state <= TOP_IDLE;
                default:              state <= TOP_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.char_idx = idx;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Bench for msg_uart_tx: one instance with CR LF, one text-only, both at 4 clocks per bit.
module tb_msg_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    int   checks = 0;
    int   passes = 0;
    string text = "Hello, World!";

    always #5 clk = ~clk;

    msg_uart_tx_if if_a ();
    msg_uart_tx_if if_b ();

    msg_uart_tx #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    msg_uart_tx #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );

    wire       m_txd  = sel ? if_b.txd  : if_a.txd;
    wire       m_busy = sel ? if_b.busy : if_a.busy;
    wire       m_done = sel ? if_b.done : if_a.done;
    wire [3:0] m_idx  = sel ? if_b.char_idx : if_a.char_idx;

    initial begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] c;
        if (i < 13) c = text[i];
        else if (i == 13) c = 8'h0D;
        else c = 8'h0A;
        return c;
    endfunction

    // Line level k cycles after start was taken (k >= 1), from frame arithmetic alone.
    function automatic logic exp_txd(input int k);
        int p, b, j;
        logic [7:0] c;
        p = k - 1;
        b = p / (10 * CPB);
        j = (p % (10 * CPB)) / CPB;
        c = exp_byte(b);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return c[j-1];
    endfunction

    task automatic set_start(input logic v);
        if (sel) if_b.start = v;
        else     if_a.start = v;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({if_a.txd, if_a.busy, if_a.done, if_a.char_idx} !== 7'b1000000)
                $display("FAIL reset_a cyc%0d: got txd/busy/done/idx=%b/%b/%b/%0d want 1/0/0/0",
                         i, if_a.txd, if_a.busy, if_a.done, if_a.char_idx);
            else passes++;
            checks++;
            if ({if_b.txd, if_b.busy, if_b.done, if_b.char_idx} !== 7'b1000000)
                $display("FAIL reset_b cyc%0d: got txd/busy/done/idx=%b/%b/%b/%0d want 1/0/0/0",
                         i, if_b.txd, if_b.busy, if_b.done, if_b.char_idx);
            else passes++;
        end
    endtask

    // Start one message on the selected instance and check it cycle by cycle.
    task automatic send_and_check(input string name, input int ign0, input int ign1, input bit hold);
        int L, tot, last, j, seen;
        logic et, eb, ed;
        logic [3:0] ei;
        logic [7:0] sh;
        logic [7:0] rx[$];
        L    = sel ? 13 : 15;
        tot  = L * 10 * CPB;
        last = hold ? tot + 3 : tot + 2;
        sh   = '0;
        @(negedge clk);
        set_start(1'b1);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            set_start(hold || k == ign0 || k == ign1);
            if (k <= tot) begin
                et = exp_txd(k); eb = 1'b1; ed = 1'b0; ei = 4'((k - 1) / (10 * CPB));
            end else if (k == tot + 1) begin
                et = 1'b1; eb = 1'b0; ed = 1'b1; ei = 4'd0;
            end else if (k == tot + 2) begin
                et = 1'b1; eb = 1'b0; ed = 1'b0; ei = 4'd0;
            end else begin
                et = 1'b0; eb = 1'b1; ed = 1'b0; ei = 4'd0;
            end
            checks++;
            if (m_txd !== et) $display("FAIL %s txd k=%0d: got %b want %b", name, k, m_txd, et);
            else passes++;
            checks++;
            if (m_busy !== eb) $display("FAIL %s busy k=%0d: got %b want %b", name, k, m_busy, eb);
            else passes++;
            checks++;
            if (m_done !== ed) $display("FAIL %s done k=%0d: got %b want %b", name, k, m_done, ed);
            else passes++;
            checks++;
            if (m_idx !== ei) $display("FAIL %s char_idx k=%0d: got %0d want %0d", name, k, m_idx, ei);
            else passes++;
            if (k <= tot && ((k - 1) % CPB) == CPB / 2) begin
                j = ((k - 1) % (10 * CPB)) / CPB;
                if (j >= 1 && j <= 8) sh[j-1] = m_txd;
                if (j == 8) rx.push_back(sh);
            end
        end
        set_start(1'b0);
        checks++;
        if (rx.size() !== L) $display("FAIL %s byte_count: got %0d want %0d", name, rx.size(), L);
        else passes++;
        for (int i = 0; i < L && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_byte(i))
                $display("FAIL %s byte%0d: got %h want %h", name, i, rx[i], exp_byte(i));
            else passes++;
        end
        if (hold) begin
            seen = 0;
            for (int c = 0; c < tot + 5; c++) begin
                @(negedge clk);
                if (m_done === 1'b1) seen++;
            end
            checks++;
            if (seen !== 1) $display("FAIL %s second_msg_done: got %0d pulses want 1", name, seen);
            else passes++;
        end
    endtask

    task automatic test_first_byte();
        logic [9:0] pat;
        int waited;
        pat = 10'b1010010000;  // bit i = level of the i-th bit time of 'H'
        sel = 1'b0;
        @(negedge clk);
        set_start(1'b1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            set_start(1'b0);
            checks++;
            if (m_txd !== pat[(k - 1) / CPB])
                $display("FAIL first_byte k=%0d: got %b want %b", k, m_txd, pat[(k - 1) / CPB]);
            else passes++;
        end
        waited = 0;
        while (m_done !== 1'b1 && waited < 700) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (m_done !== 1'b1) $display("FAIL first_byte_done: got %b want 1 within budget", m_done);
        else passes++;
    endtask

    task automatic test_quiet_after(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({m_busy, m_done} !== 2'b00)
                $display("FAIL %s quiet cyc%0d: got busy/done=%b/%b want 0/0", name, i, m_busy, m_done);
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        int target;
        sel = 1'b0;
        target = 213 + $urandom_range(0, 3);  // byte 5, bit 3
        @(negedge clk);
        set_start(1'b1);
        for (int k = 1; k <= target; k++) begin
            @(negedge clk);
            set_start(1'b0);
        end
        checks++;
        if (m_idx !== 4'd5) $display("FAIL midrst_pre_idx: got %0d want 5", m_idx);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_txd, m_busy, m_done, m_idx} !== 7'b1000000)
            $display("FAIL midrst_after: got txd/busy/done/idx=%b/%b/%b/%0d want 1/0/0/0",
                     m_txd, m_busy, m_done, m_idx);
        else passes++;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({m_txd, m_done} !== 2'b10)
                $display("FAIL midrst_quiet cyc%0d: got txd/done=%b/%b want 1/0", i, m_txd, m_done);
            else passes++;
        end
        send_and_check("after_reset", 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();

        sel = 1'b0;
        for (int r = 0; r < 2; r++) begin
            idle_gap($urandom_range(1, 20));
            send_and_check("crlf", 0, 0, 1'b0);
        end

        idle_gap($urandom_range(1, 10));
        test_first_byte();

        sel = 1'b1;
        idle_gap($urandom_range(1, 10));
        send_and_check("text_ign", 50, 300, 1'b0);
        test_quiet_after("text_ign");
        send_and_check("text_rnd", $urandom_range(2, 519), $urandom_range(2, 519), 1'b0);
        test_quiet_after("text_rnd");

        sel = 1'b0;
        idle_gap($urandom_range(1, 10));
        send_and_check("hold", 0, 0, 1'b1);

        idle_gap($urandom_range(1, 10));
        test_mid_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
